// File: rtl/vgalcd_pixfmt_pkg.sv
// Shared pixel-mode encodings, pixels-per-word constants and the RGB888 payload type
// for the vgalcd pixel output stage.
package vgalcd_pixfmt_pkg;

  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] VGALCD_PIXMODE_888 = 2'd0;
  localparam logic [1:0] VGALCD_PIXMODE_565 = 2'd1;
  localparam logic [1:0] VGALCD_PIXMODE_332 = 2'd2;
  localparam logic [1:0] VGALCD_PIXMODE_RSV = 2'd3;

  localparam int unsigned VGALCD_PPW_888 = 1;
  localparam int unsigned VGALCD_PPW_565 = 2;
  localparam int unsigned VGALCD_PPW_332 = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Index of the final pixel in a word; the reserved mode unpacks like 888.
  function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] mode);
    case (mode)
      VGALCD_PIXMODE_565: last_idx = IDX_W'(VGALCD_PPW_565 - 1);
      VGALCD_PIXMODE_332: last_idx = IDX_W'(VGALCD_PPW_332 - 1);
      VGALCD_PIXMODE_888,
      VGALCD_PIXMODE_RSV: last_idx = IDX_W'(VGALCD_PPW_888 - 1);
      default:            last_idx = IDX_W'(VGALCD_PPW_888 - 1);
    endcase
  endfunction

endpackage

// File: rtl/vgalcd_pixexp.sv
// Combinational unpacker: selects one pixel of a packed word and expands it to RGB888
// by MSB replication.
module vgalcd_pixexp
  import vgalcd_pixfmt_pkg::*;
(
  input  logic [31:0]      word_i,
  input  logic [1:0]       mode_i,
  input  logic [IDX_W-1:0] idx_i,
  output rgb888_t          rgb_c
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    half  = idx_i[0] ? word_i[31:16] : word_i[15:0];
    byt   = word_i[7:0];
    rgb_c = '0;
    case (idx_i)
      2'd1:    byt = word_i[15:8];
      2'd2:    byt = word_i[23:16];
      2'd3:    byt = word_i[31:24];
      default: byt = word_i[7:0];
    endcase
    case (mode_i)
      VGALCD_PIXMODE_565: begin
        rgb_c.r = {half[15:11], half[15:13]};
        rgb_c.g = {half[10:5],  half[10:9]};
        rgb_c.b = {half[4:0],   half[4:2]};
      end
      VGALCD_PIXMODE_332: begin
        rgb_c.r = {byt[7:5], byt[7:5], byt[7:6]};
        rgb_c.g = {byt[4:2], byt[4:2], byt[4:3]};
        rgb_c.b = {4{byt[1:0]}};
      end
      default: rgb_c = rgb888_t'(word_i[23:0]);
    endcase
  end

endmodule

// File: rtl/vgalcd_pixfmt.sv
// Panel pixel output stage: fetches packed words from the frame FIFO, unpacks per pixel
// mode and drives registered rgb/de/hsync/vsync aligned one tick behind the timing counters.
module vgalcd_pixfmt
  import vgalcd_pixfmt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RGB_WIDTH  = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic                  hpol_i,
  input  logic                  vpol_i,
  input  logic                  hvis_i,
  input  logic                  vvis_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic                  vend_i,
  input  logic                  pix_valid_i,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  output logic                  pix_ready_o,
  output logic [RGB_WIDTH-1:0]  rgb_o,
  output logic                  de_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  udf_o
);

  logic                  active;
  logic                  fetch;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            mode_q, mode_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RGB_WIDTH-1:0]  rgb_q, rgb_d;
  logic                  de_q, de_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [1:0]            exp_mode;
  rgb888_t               exp_rgb;

  assign active      = hvis_i & vvis_i;
  assign fetch       = (idx_q == '0);
  assign pix_ready_o = rst_n_i & en_i & active & fetch;

  // One expander: the live FIFO word at a fetch, the held word otherwise.
  assign exp_word = fetch ? pix_data_i : word_q;
  assign exp_mode = fetch ? mode_i : mode_q;

  vgalcd_pixexp u_pixexp (
    .word_i (exp_word),
    .mode_i (exp_mode),
    .idx_i  (idx_q),
    .rgb_c  (exp_rgb)
  );

  always_comb begin
    word_d  = word_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    udf_d   = 1'b0;
    if (en_i) begin
      hsync_d = hpol_i ? hsync_i : ~hsync_i;
      vsync_d = vpol_i ? vsync_i : ~vsync_i;
      if (!active) begin
        idx_d = '0;
        rgb_d = '0;
        de_d  = 1'b0;
      end else if (!fetch) begin
        rgb_d = exp_rgb;
        de_d  = 1'b1;
        idx_d = (idx_q == last_idx(mode_q)) ? '0 : idx_q + IDX_W'(1);
      end else if (pix_valid_i) begin
        word_d = pix_data_i;
        mode_d = mode_i;
        rgb_d  = exp_rgb;
        de_d   = 1'b1;
        idx_d  = (last_idx(mode_i) == '0) ? '0 : IDX_W'(1);
      end else begin
        // Starved at a fetch slot: blank pixel, keep de so panel timing is intact.
        rgb_d = '0;
        de_d  = 1'b1;
        udf_d = 1'b1;
      end
      if (vend_i) idx_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q  <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      udf_q   <= udf_d;
    end
  end

  assign rgb_o   = rgb_q;
  assign de_o    = de_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign udf_o   = udf_q;

endmodule

// File: tb/tb_vgalcd_pixfmt.sv
// Bench for vgalcd_pixfmt: directed vector table, hand-written sync/hold/reset sequences,
// then random traffic against a pixel-queue reference model.
module tb_vgalcd_pixfmt;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i, hpol_i, vpol_i, hvis_i, vvis_i, hsync_i, vsync_i, vend_i, pix_valid_i;
  logic [1:0]  mode_i;
  logic [31:0] pix_data_i;
  logic        pix_ready_o, de_o, hsync_o, vsync_o, udf_o;
  logic [23:0] rgb_o;

  vgalcd_pixfmt dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .mode_i(mode_i),
    .hpol_i(hpol_i), .vpol_i(vpol_i), .hvis_i(hvis_i), .vvis_i(vvis_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .vend_i(vend_i),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
    .rgb_o(rgb_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of already-expanded pixels still owed from the current word.
  logic [23:0] m_q[$];
  logic [23:0] m_rgb;
  logic        m_de, m_hs, m_vs, m_udf, m_ready;

  typedef struct {
    logic        en, hv, vv, vld, vend;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        rdy;
    logic [23:0] rgb;
    logic        de, udf;
  } tvec_t;

  tvec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] decode(input logic [31:0] w, input logic [1:0] m, input int k);
    int v, r, g, b;
    if (m == 2'd1) begin
      v = int'((w >> (16 * k)) & 32'hFFFF);
      r = (v >> 11) % 32; g = (v >> 5) % 64; b = v % 32;
      return 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
    end else if (m == 2'd2) begin
      v = int'((w >> (8 * k)) & 32'hFF);
      r = v / 32; g = (v / 4) % 8; b = v % 4;
      return 24'((r * 32 + r * 4 + r / 2) * 65536 + (g * 32 + g * 4 + g / 2) * 256 + b * 85);
    end
    return w[23:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rgb = '0; m_de = 0; m_hs = 0; m_vs = 0; m_udf = 0;
  endtask

  task automatic model_step();
    int n;
    m_udf = 1'b0;
    if (en_i) begin
      m_hs = hpol_i ? hsync_i : ~hsync_i;
      m_vs = vpol_i ? vsync_i : ~vsync_i;
      if (hvis_i && vvis_i) begin
        if (m_q.size() == 0) begin
          if (pix_valid_i) begin
            n = (mode_i == 2'd1) ? 2 : (mode_i == 2'd2) ? 4 : 1;
            for (int k = 0; k < n; k++) m_q.push_back(decode(pix_data_i, mode_i, k));
            m_rgb = m_q.pop_front();
            m_de  = 1'b1;
          end else begin
            m_rgb = '0; m_de = 1'b1; m_udf = 1'b1;
          end
        end else begin
          m_rgb = m_q.pop_front();
          m_de  = 1'b1;
        end
      end else begin
        m_q.delete();
        m_rgb = '0; m_de = 1'b0;
      end
      if (vend_i) m_q.delete();
    end
  endtask

  // Sample ready before the edge, advance model and DUT by one clock, settle #1 after.
  task automatic run_cycle(output logic rdy_seen);
    #1;
    rdy_seen = pix_ready_o;
    m_ready  = rst_n_i & en_i & hvis_i & vvis_i & (m_q.size() == 0);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_model(input string tag, input logic rdy);
    chk({tag, "_ready"}, 32'(rdy), 32'(m_ready));
    chk({tag, "_rgb"}, 32'(rgb_o), 32'(m_rgb));
    chk({tag, "_de"}, 32'(de_o), 32'(m_de));
    chk({tag, "_hsync"}, 32'(hsync_o), 32'(m_hs));
    chk({tag, "_vsync"}, 32'(vsync_o), 32'(m_vs));
    chk({tag, "_udf"}, 32'(udf_o), 32'(m_udf));
  endtask

  initial begin
    logic rdy;
    //            en hv vv vld vend mode  data           rdy rgb         de udf
    tbl[0]  = '{1, 1, 1, 1, 0, 2'd0, 32'h00112233, 1, 24'h112233, 1, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 2'd0, 32'h00445566, 1, 24'h445566, 1, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 2'd1, 32'hF80007E0, 1, 24'h00FF00, 1, 0};
    tbl[3]  = '{1, 1, 1, 1, 0, 2'd1, 32'hDEADBEEF, 0, 24'hFF0000, 1, 0};
    tbl[4]  = '{1, 1, 1, 1, 0, 2'd2, 32'h03E01CFF, 1, 24'hFFFFFF, 1, 0};
    tbl[5]  = '{1, 1, 1, 1, 0, 2'd0, 32'h00000000, 0, 24'h00FF00, 1, 0};
    tbl[6]  = '{1, 1, 1, 1, 0, 2'd0, 32'h00000000, 0, 24'hFF0000, 1, 0};
    tbl[7]  = '{1, 1, 1, 1, 0, 2'd0, 32'h00000000, 0, 24'h0000FF, 1, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 2'd1, 32'h00000000, 1, 24'h000000, 1, 1};
    tbl[9]  = '{1, 1, 1, 1, 0, 2'd1, 32'h001FFFFF, 1, 24'hFFFFFF, 1, 0};
    tbl[10] = '{0, 1, 1, 1, 0, 2'd1, 32'h00000000, 0, 24'hFFFFFF, 1, 0};
    tbl[11] = '{1, 0, 1, 1, 0, 2'd1, 32'h00000000, 0, 24'h000000, 0, 0};
    tbl[12] = '{1, 1, 1, 1, 0, 2'd2, 32'h12345678, 1, 24'h6DDB00, 1, 0};
    tbl[13] = '{1, 1, 1, 1, 1, 2'd2, 32'h00000000, 0, 24'h49B6AA, 1, 0};
    tbl[14] = '{1, 1, 1, 1, 0, 2'd0, 32'h00A1B2C3, 1, 24'hA1B2C3, 1, 0};
    tbl[15] = '{1, 1, 0, 1, 0, 2'd0, 32'h00000000, 0, 24'h000000, 0, 0};

    // Reset with an active tick presented: ready must stay low, outputs zero.
    rst_n_i = 0; en_i = 1; hvis_i = 1; vvis_i = 1; pix_valid_i = 1;
    hpol_i = 1; vpol_i = 1; hsync_i = 0; vsync_i = 0; vend_i = 0;
    mode_i = 0; pix_data_i = 32'h00ABCDEF;
    model_reset();
    #12;
    chk("rst_ready", 32'(pix_ready_o), 0);
    chk("rst_rgb", 32'(rgb_o), 0);
    chk("rst_de", 32'(de_o), 0);
    chk("rst_sync", 32'({hsync_o, vsync_o, udf_o}), 0);
    @(negedge clk_i); rst_n_i = 1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 16; i++) begin
      en_i = tbl[i].en; hvis_i = tbl[i].hv; vvis_i = tbl[i].vv;
      pix_valid_i = tbl[i].vld; vend_i = tbl[i].vend;
      mode_i = tbl[i].mode; pix_data_i = tbl[i].data;
      run_cycle(rdy);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rgb", i), 32'(rgb_o), 32'(tbl[i].rgb));
      chk($sformatf("tbl%0d_de", i), 32'(de_o), 32'(tbl[i].de));
      chk($sformatf("tbl%0d_udf", i), 32'(udf_o), 32'(tbl[i].udf));
    end

    // Sync polarity, then hold while en_i is low.
    en_i = 1; hvis_i = 0; vend_i = 0; hpol_i = 0; vpol_i = 1; hsync_i = 1; vsync_i = 1;
    run_cycle(rdy);
    chk("pol_hsync", 32'(hsync_o), 0);
    chk("pol_vsync", 32'(vsync_o), 1);
    en_i = 0; hsync_i = 0; vsync_i = 0; hvis_i = 1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(rdy);
      chk("hold_sync", 32'({hsync_o, vsync_o}), 32'(2'b01));
      chk("hold_de", 32'(de_o), 0);
    end
    en_i = 1; hvis_i = 0;
    run_cycle(rdy);
    chk("pol2_sync", 32'({hsync_o, vsync_o}), 32'(2'b10));

    // Async reset mid-word: outputs clear at once, next fetch restarts at pixel 0.
    hvis_i = 1; vvis_i = 1; pix_valid_i = 1; mode_i = 2'd2; pix_data_i = 32'hA5C3E7FF;
    run_cycle(rdy);
    chk_model("pre_rst", rdy);
    #2 rst_n_i = 0;
    #1;
    chk("arst_rgb", 32'(rgb_o), 0);
    chk("arst_flags", 32'({de_o, hsync_o, vsync_o, udf_o}), 0);
    chk("arst_ready", 32'(pix_ready_o), 0);
    model_reset();
    #1 rst_n_i = 1;
    mode_i = 2'd1; pix_data_i = 32'h07E0F81F;
    run_cycle(rdy);
    chk_model("post_rst", rdy);
    chk("post_rst_pix0", 32'(rgb_o), 32'h00FF00FF);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en_i        = ($urandom_range(0, 9) < 7);
      hvis_i      = ($urandom_range(0, 9) < 8);
      vvis_i      = ($urandom_range(0, 19) < 19);
      pix_valid_i = ($urandom_range(0, 9) < 8);
      vend_i      = ($urandom_range(0, 31) == 0);
      mode_i      = 2'($urandom_range(0, 3));
      pix_data_i  = $urandom;
      hsync_i     = 1'($urandom_range(0, 1));
      vsync_i     = 1'($urandom_range(0, 1));
      hpol_i      = 1'($urandom_range(0, 1));
      vpol_i      = 1'($urandom_range(0, 1));
      run_cycle(rdy);
      chk_model("rnd", rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
